instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 103 ++++++++++
 tb/tb_instr_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: reads opcodes from a one-cycle-latency memory,
// resolves JUMNZ locally and hands every other opcode to the decoder.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W   = 8,
  parameter logic [7:0]  OP_JUMNZ = 8'd40,
  parameter logic [7:0]  OP_END   = 8'd38
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en_n,
  input  logic [7:0]        mem_data,
  input  logic              z_flag,
  output logic [7:0]        instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, ISSUE, TGT_FETCH, TGT_WAIT, HALT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] jump_pc;

  assign pc_inc  = pc + ADDR_W'(1);
  // Taken jump loads the target byte; not-taken skips past it.
  assign jump_pc = z_flag ? pc_inc : ADDR_W'(mem_data);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      mem_addr    <= '0;
      mem_en_n    <= 1'b1;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      unique case (state)
        IDLE, HALT: begin
          if (start) begin
            pc       <= '0;
            mem_addr <= '0;
            mem_en_n <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          mem_en_n <= 1'b1;
          state    <= WAIT;
        end
        WAIT: begin
          if (mem_data == OP_JUMNZ) begin
            pc       <= pc_inc;
            mem_addr <= pc_inc;
            mem_en_n <= 1'b0;
            state    <= TGT_FETCH;
          end else begin
            instr_out   <= mem_data;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
            if (instr_out == OP_END && z_flag) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= HALT;
            end else begin
              pc       <= pc_inc;
              mem_addr <= pc_inc;
              mem_en_n <= 1'b0;
              state    <= FETCH;
            end
          end
        end
        TGT_FETCH: begin
          mem_en_n <= 1'b1;
          state    <= TGT_WAIT;
        end
        TGT_WAIT: begin
          pc       <= jump_pc;
          mem_addr <= jump_pc;
          mem_en_n <= 1'b0;
          state    <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed programs and random
// programs compared against a program-level interpreter.
module tb_instr_fetch_unit;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] mem_addr;
  logic       mem_en_n;
  logic [7:0] mem_data = '0;
  logic       z_flag;
  logic [7:0] instr_out;
  logic       instr_valid;
  logic       instr_ready;
  logic       busy;
  logic       done;

  instr_fetch_unit #(.ADDR_W(8), .OP_JUMNZ(8'd40), .OP_END(8'd38)) dut (
    .clock(clock), .rst_n(rst_n), .start(start),
    .mem_addr(mem_addr), .mem_en_n(mem_en_n), .mem_data(mem_data),
    .z_flag(z_flag), .instr_out(instr_out), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [256];
  always @(posedge clock) if (!mem_en_n) mem_data <= mem[mem_addr];

  // z_flag changes only when the decoder accepts an opcode
  bit zseq [64];
  int hs_count = 0;
  int hs_base  = 0;
  assign z_flag = zseq[(hs_count - hs_base) & 63];

  bit ready_dir = 1'b1;
  bit rnd_ready = 1'b0;
  bit rnd_bit   = 1'b1;
  always @(negedge clock) rnd_bit <= ($urandom_range(0, 9) < 7);
  assign instr_ready = rnd_ready ? rnd_bit : ready_dir;

  int cyc = 0;
  int addr_log[$];
  int ins_log[$];
  int hs_cyc[$];
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (rst_n && !mem_en_n) addr_log.push_back(int'(mem_addr));
    if (rst_n && instr_valid && instr_ready) begin
      ins_log.push_back(int'(instr_out));
      hs_cyc.push_back(cyc);
      hs_count <= hs_count + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference interpreter: walks the program as the ISA defines it.
  int m_addr[$];
  int m_ins[$];
  bit m_halt;
  task automatic model(input int max_fetch);
    logic [7:0] pc;
    logic [7:0] op;
    int n;
    m_addr.delete(); m_ins.delete(); m_halt = 0; pc = '0; n = 0;
    while (m_addr.size() < max_fetch) begin
      m_addr.push_back(int'(pc));
      op = mem[pc];
      if (op == 8'd40) begin
        pc = pc + 8'd1;
        m_addr.push_back(int'(pc));
        pc = zseq[n & 63] ? pc + 8'd1 : mem[pc];
      end else begin
        m_ins.push_back(int'(op));
        if (op == 8'd38 && zseq[n & 63]) begin
          m_halt = 1;
          break;
        end
        n++;
        pc = pc + 8'd1;
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 64; i++) zseq[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst_n = 1'b0; start = 1'b0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
  endtask

  int a0, i0;
  task automatic run_prog(input string tag, input int max_fetch, input bit with_reset);
    bit fin;
    int na;
    if (with_reset) do_reset();
    model(max_fetch);
    a0 = addr_log.size(); i0 = ins_log.size(); hs_base = hs_count;
    start = 1'b1; @(negedge clock); start = 1'b0;
    fin = 0;
    for (int c = 0; c < 3000; c++) begin
      if (addr_log.size() - a0 >= m_addr.size() && ins_log.size() - i0 >= m_ins.size()
          && (!m_halt || done)) begin
        fin = 1;
        break;
      end
      @(negedge clock);
    end
    check({tag, " finished"}, int'(fin), 1);
    for (int k = 0; k < m_addr.size(); k++)
      check($sformatf("%s addr[%0d]", tag, k),
            (a0 + k < addr_log.size()) ? addr_log[a0 + k] : -1, m_addr[k]);
    for (int k = 0; k < m_ins.size(); k++)
      check($sformatf("%s instr[%0d]", tag, k),
            (i0 + k < ins_log.size()) ? ins_log[i0 + k] : -1, m_ins[k]);
    if (m_halt) begin
      check({tag, " done"}, int'(done), 1);
      check({tag, " busy"}, int'(busy), 0);
      na = addr_log.size();
      repeat (10) @(negedge clock);
      check({tag, " no fetch in HALT"}, addr_log.size(), na);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " mem_addr"}, int'(mem_addr), 0);
    check({tag, " mem_en_n"}, int'(mem_en_n), 1);
    check({tag, " instr_out"}, int'(instr_out), 0);
    check({tag, " instr_valid"}, int'(instr_valid), 0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " done"}, int'(done), 0);
  endtask

  initial begin
    bit fin;
    int cnt;
    start = 1'b0;
    rst_n = 1'b1;
    clear_mem();
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");

    // Linear run with handshake spacing
    mem[0] = 8'd8; mem[1] = 8'd9; mem[2] = 8'd11; mem[3] = 8'd38; zseq[3] = 1'b1;
    run_prog("linear", 10, 1);
    if (ins_log.size() >= i0 + 3) begin
      check("linear spacing 0-1", hs_cyc[i0 + 1] - hs_cyc[i0], 3);
      check("linear spacing 1-2", hs_cyc[i0 + 2] - hs_cyc[i0 + 1], 3);
    end else check("linear handshakes", ins_log.size() - i0, 3);

    // Taken jump 5 -> 28
    clear_mem();
    for (int i = 0; i < 5; i++) mem[i] = 8'(10 + i);
    mem[5] = 8'd40; mem[6] = 8'd28; mem[28] = 8'd15; mem[29] = 8'd38;
    mem[7] = 8'd16; mem[8] = 8'd38;
    zseq[6] = 1'b1;
    run_prog("taken", 20, 1);
    cnt = 0;
    for (int k = i0; k < ins_log.size(); k++) if (ins_log[k] == 40) cnt++;
    check("taken no JUMNZ forwarded", cnt, 0);

    // Not-taken jump falls through to 7
    zseq[5] = 1'b1;
    run_prog("not_taken", 20, 1);

    // END halts only with z=1; restart from HALT without reset
    clear_mem();
    mem[0] = 8'd40; mem[1] = 8'd11; mem[11] = 8'd9; mem[12] = 8'd38;
    mem[13] = 8'd21; mem[14] = 8'd38;
    zseq[1] = 1'b1;
    run_prog("end_z1", 20, 1);
    zseq[1] = 1'b0; zseq[2] = 1'b1;
    run_prog("end_z0", 20, 0);

    // pc wrap 255 -> 0 on the target fetch
    clear_mem();
    mem[0] = 8'd40; mem[1] = 8'd254; mem[254] = 8'd5; mem[255] = 8'd40; mem[2] = 8'd38;
    zseq[1] = 1'b1; zseq[2] = 1'b1;
    run_prog("wrap", 20, 1);

    // Back-to-back JUMNZ, including a target holding JUMNZ
    clear_mem();
    mem[0] = 8'd40; mem[1] = 8'd4; mem[4] = 8'd40; mem[5] = 8'd8;
    mem[8] = 8'd40; mem[9] = 8'd12; mem[12] = 8'd7; mem[13] = 8'd38;
    zseq[1] = 1'b1;
    run_prog("b2b_jumnz", 20, 1);

    // Backpressure
    clear_mem();
    mem[0] = 8'd8; mem[1] = 8'd38; zseq[1] = 1'b1;
    do_reset();
    ready_dir = 1'b0;
    a0 = addr_log.size(); hs_base = hs_count;
    start = 1'b1; @(negedge clock); start = 1'b0;
    fin = 0;
    for (int c = 0; c < 20; c++) begin
      if (instr_valid) begin fin = 1; break; end
      @(negedge clock);
    end
    check("bp valid seen", int'(fin), 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("bp instr_out stable", int'(instr_out), 8);
      check("bp instr_valid stable", int'(instr_valid), 1);
      check("bp mem_en_n idle", int'(mem_en_n), 1);
    end
    check("bp no extra fetch", addr_log.size() - a0, 1);
    ready_dir = 1'b1;
    fin = 0;
    for (int c = 0; c < 10; c++) begin
      if (addr_log.size() - a0 >= 2) begin fin = 1; break; end
      @(negedge clock);
    end
    check("bp resume fetch", fin ? addr_log[a0 + 1] : -1, 1);

    // Async reset in TGT_WAIT
    clear_mem();
    mem[0] = 8'd40; mem[1] = 8'd30;
    do_reset();
    a0 = addr_log.size(); hs_base = hs_count;
    start = 1'b1; @(negedge clock); start = 1'b0;
    fin = 0;
    for (int c = 0; c < 20; c++) begin
      if (addr_log.size() - a0 >= 2) begin fin = 1; break; end
      @(negedge clock);
    end
    check("arst reached TGT_WAIT", int'(fin), 1);
    check("arst busy before", int'(busy), 1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("arst");
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    a0 = addr_log.size();
    for (int c = 0; c < 6; c++) begin
      zseq[0] = ~zseq[0]; ready_dir = ~ready_dir;
      @(negedge clock);
    end
    ready_dir = 1'b1;
    check("arst idle no fetch", addr_log.size() - a0, 0);
    check("arst idle busy", int'(busy), 0);
    start = 1'b1; @(negedge clock); start = 1'b0;
    fin = 0;
    for (int c = 0; c < 10; c++) begin
      if (addr_log.size() > a0) begin fin = 1; break; end
      @(negedge clock);
    end
    check("arst restart addr", fin ? addr_log[a0] : -1, 0);

    // Random programs with random backpressure
    rnd_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 256; i++) begin
        int p;
        p = int'($urandom_range(0, 99));
        if (p < 25) mem[i] = 8'd40;
        else if (p < 37) mem[i] = 8'd38;
        else begin
          mem[i] = 8'($urandom_range(0, 255));
          if (mem[i] == 8'd40 || mem[i] == 8'd38) mem[i] = 8'd0;
        end
      end
      for (int i = 0; i < 64; i++) zseq[i] = 1'($urandom_range(0, 1));
      run_prog($sformatf("rand%0d", r), 40, 1);
    end
    rnd_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
